// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage between EX/MA and MA/WB.
// ALU results pass straight through in one cycle; loads and stores go through
// a two-state FSM (IDLE/BUS) that drives a simple req/ack bus, shifts store data
// into its byte lanes, extracts and extends load data, and raises an access
// fault when no ack arrives within TIMEOUT_CYCLES bus cycles.
// Optional feature macro MA_MISALIGN_TRAP_EN: misaligned memory ops trap with
// misalign_out instead of reaching the bus. Without it the byte offset is
// forced to natural alignment and misalign_out stays 0.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        valid_in,
    input  logic [63:0] pc_in,
    input  logic [4:0]  rd_in,
    input  logic [63:0] result_in,
    input  logic [63:0] data2_in,
    input  logic        load_op,
    input  logic        store_op,
    input  logic [1:0]  size,
    input  logic        unsigned_op,
    output logic        stall_out,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [63:0] bus_rdata,
    output logic        valid_out,
    output logic [63:0] pc_out,
    output logic [4:0]  rd_out,
    output logic [63:0] result_out,
    output logic        fault_out,
    output logic        misalign_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    // Wait-counter value on the last bus cycle before the fault is declared.
    localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_flush;
    logic        w_flush_nxt;

    logic        r_valid_p1;
    logic        r_fault_p1;
    logic        r_misalign_p1;
    logic [63:0] r_pc_p1;
    logic [4:0]  r_rd_p1;
    logic [63:0] r_result_p1;

    logic        w_mem_op;
    logic [2:0]  w_align_mask;
    logic [7:0]  w_strb_base;
    logic [2:0]  w_off;
    logic        w_trap;
    logic        w_timeout;
    logic [63:0] w_rdata_sh;
    logic [63:0] w_load_val;

    logic        w_stall;
    logic        w_bus_req;
    logic        w_load;
    logic        w_ld_valid;
    logic        w_ld_fault;
    logic        w_ld_mis;
    logic [4:0]  w_ld_rd;
    logic [63:0] w_ld_result;

    // Truncate the lane-aligned read data to the access size and extend it.
    function automatic logic [63:0] f_load_ext(input logic [63:0] d,
                                               input logic [1:0]  sz,
                                               input logic        uns);
        logic [63:0] v;
        case (sz)
            2'd0:    v = uns ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
            2'd1:    v = uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
            2'd2:    v = uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
            default: v = d;
        endcase
        return v;
    endfunction

    assign w_mem_op  = load_op | store_op;
    assign w_timeout = (r_wait_cnt == LP_TO_LAST);

    // Low address bits that must be zero for a naturally aligned access, and base strobe.
    always_comb begin
        case (size)
            2'd0:    begin w_align_mask = 3'b000; w_strb_base = 8'h01; end
            2'd1:    begin w_align_mask = 3'b001; w_strb_base = 8'h03; end
            2'd2:    begin w_align_mask = 3'b011; w_strb_base = 8'h0F; end
            default: begin w_align_mask = 3'b111; w_strb_base = 8'hFF; end
        endcase
    end

`ifdef MA_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = |(result_in[2:0] & w_align_mask);
    assign w_off        = result_in[2:0];
    assign w_trap       = w_mem_op & w_misaligned;
    assign misalign_out = r_misalign_p1;
`else
    assign w_off        = result_in[2:0] & ~w_align_mask;
    assign w_trap       = 1'b0;
    assign misalign_out = 1'b0;
`endif

    assign w_rdata_sh = bus_rdata >> {w_off, 3'b000};
    assign w_load_val = f_load_ext(w_rdata_sh, size, unsigned_op);

    // Next state, stall, bus request and MA/WB load values; defaults first.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        w_flush_nxt = r_flush;
        w_stall     = 1'b0;
        w_bus_req   = 1'b0;
        w_load      = 1'b0;
        w_ld_valid  = 1'b0;
        w_ld_fault  = 1'b0;
        w_ld_mis    = 1'b0;
        w_ld_rd     = rd_in;
        w_ld_result = result_in;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt   = 16'd0;
                w_flush_nxt = 1'b0;
                if (clear || !valid_in) begin
                    w_load = 1'b0;
                end else if (w_trap) begin
                    w_load     = 1'b1;
                    w_ld_valid = 1'b1;
                    w_ld_mis   = 1'b1;
                    w_ld_rd    = store_op ? 5'd0 : rd_in;
                end else if (w_mem_op) begin
                    w_stall     = 1'b1;
                    w_state_nxt = ST_BUS;
                end else begin
                    w_load     = 1'b1;
                    w_ld_valid = 1'b1;
                end
            end
            ST_BUS: begin
                w_bus_req = 1'b1;
                if (bus_ack || w_timeout) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_flush_nxt = 1'b0;
                    w_ld_valid  = !(r_flush || clear);
                    w_ld_fault  = !bus_ack && !(r_flush || clear);
                    w_ld_rd     = store_op ? 5'd0 : rd_in;
                    if (!bus_ack)
                        w_ld_result = result_in;
                    else if (store_op)
                        w_ld_result = 64'd0;
                    else
                        w_ld_result = w_load_val;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_wait_cnt + 16'd1;
                    if (clear)
                        w_flush_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, bus wait counter and sticky flush flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 16'd0;
            r_flush    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
            r_flush    <= w_flush_nxt;
        end
    end

    // MA/WB register: loads on completion, otherwise a bubble with faults cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_p1    <= 1'b0;
            r_fault_p1    <= 1'b0;
            r_misalign_p1 <= 1'b0;
            r_pc_p1       <= 64'd0;
            r_rd_p1       <= 5'd0;
            r_result_p1   <= 64'd0;
        end else if (w_load) begin
            r_valid_p1    <= w_ld_valid;
            r_fault_p1    <= w_ld_fault;
            r_misalign_p1 <= w_ld_mis;
            r_pc_p1       <= pc_in;
            r_rd_p1       <= w_ld_rd;
            r_result_p1   <= w_ld_result;
        end else begin
            r_valid_p1    <= 1'b0;
            r_fault_p1    <= 1'b0;
            r_misalign_p1 <= 1'b0;
        end
    end

    assign stall_out  = w_stall;
    assign bus_req    = w_bus_req;
    assign bus_we     = w_bus_req & store_op;
    assign bus_addr   = w_bus_req ? {result_in[63:3], 3'b000} : 64'd0;
    assign bus_wstrb  = w_bus_req ? (w_strb_base << w_off) : 8'd0;
    assign bus_wdata  = w_bus_req ? (data2_in << {w_off, 3'b000}) : 64'd0;

    assign valid_out  = r_valid_p1;
    assign fault_out  = r_fault_p1;
    assign pc_out     = r_pc_p1;
    assign rd_out     = r_rd_p1;
    assign result_out = r_result_p1;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized instruction stream,
// checked against a transaction-level model of the stage.
module tb_mem_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        valid_in;
    logic [63:0] pc_in;
    logic [4:0]  rd_in;
    logic [63:0] result_in;
    logic [63:0] data2_in;
    logic        load_op;
    logic        store_op;
    logic [1:0]  size;
    logic        unsigned_op;
    logic        stall_out;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_ack;
    logic [63:0] bus_rdata;
    logic        valid_out;
    logic [63:0] pc_out;
    logic [4:0]  rd_out;
    logic [63:0] result_out;
    logic        fault_out;
    logic        misalign_out;

    int n_total = 0;
    int n_bad   = 0;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in),
        .pc_in(pc_in), .rd_in(rd_in), .result_in(result_in), .data2_in(data2_in),
        .load_op(load_op), .store_op(store_op), .size(size), .unsigned_op(unsigned_op),
        .stall_out(stall_out), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .valid_out(valid_out), .pc_out(pc_out), .rd_out(rd_out), .result_out(result_out),
        .fault_out(fault_out), .misalign_out(misalign_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got=running exp=done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model helpers, written from the access rules.
    function automatic int m_nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit m_misaligned(input logic [63:0] a, input logic [1:0] sz);
        return (a % m_nbytes(sz)) != 0;
    endfunction

    function automatic int m_off(input logic [63:0] a, input logic [1:0] sz);
        int nb = m_nbytes(sz);
`ifdef MA_MISALIGN_TRAP_EN
        return int'(a % 8);
`else
        return (int'(a % 8) / nb) * nb;
`endif
    endfunction

    function automatic logic [7:0] m_wstrb(input logic [63:0] a, input logic [1:0] sz);
        logic [15:0] s;
        s = 16'((1 << m_nbytes(sz)) - 1) << m_off(a, sz);
        return s[7:0];
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rdat, input logic [63:0] a,
                                           input logic [1:0] sz, input bit uns);
        int nb = m_nbytes(sz);
        logic [63:0] v;
        logic [63:0] m;
        v = rdat >> (8 * m_off(a, sz));
        m = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v = v & m;
        if (!uns && nb < 8 && v[8 * nb - 1])
            v = v | ~m;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and follow it to its writeback.
    // ack_lat: BUS cycle index (0-based) carrying the ack; >= TO means no ack.
    // clr_cyc: BUS cycle index in which clear pulses (-1 = never).
    task automatic do_op(input string nm, input bit vld, input bit ld, input bit st,
                         input logic [1:0] sz, input bit uns, input logic [63:0] addr,
                         input logic [63:0] d2, input logic [63:0] rdat,
                         input int ack_lat, input int clr_cyc, input bit clr_idle);
        logic [63:0] pc;
        logic [4:0]  rd;
        bit is_mem, trap, flushed, done, ack_now, to_now;
        pc = {$urandom, $urandom};
        rd = 5'($urandom);
        valid_in = vld; load_op = ld; store_op = st; size = sz; unsigned_op = uns;
        result_in = addr; data2_in = d2; pc_in = pc; rd_in = rd; clear = clr_idle;
        bus_ack = 1'($urandom);
        bus_rdata = {$urandom, $urandom};
        is_mem = vld && (ld || st) && !clr_idle;
`ifdef MA_MISALIGN_TRAP_EN
        trap = is_mem && m_misaligned(addr, sz);
`else
        trap = 1'b0;
`endif
        @(negedge clk);
        if (!is_mem || trap) begin
            chk({nm, ".stall"}, 64'(stall_out), 64'd0);
            chk({nm, ".req"}, 64'(bus_req), 64'd0);
            tick();
            chk({nm, ".valid"}, 64'(valid_out), 64'(vld && !clr_idle));
            chk({nm, ".fault"}, 64'(fault_out), 64'd0);
            chk({nm, ".mis"}, 64'(misalign_out), 64'(trap));
            if (vld && !clr_idle) begin
                chk({nm, ".pc"}, pc_out, pc);
                chk({nm, ".rd"}, 64'(rd_out), (trap && st) ? 64'd0 : 64'(rd));
                chk({nm, ".res"}, result_out, addr);
            end
        end else begin
            chk({nm, ".stall0"}, 64'(stall_out), 64'd1);
            chk({nm, ".req0"}, 64'(bus_req), 64'd0);
            tick();
            chk({nm, ".bubble"}, 64'(valid_out), 64'd0);
            flushed = 1'b0;
            done = 1'b0;
            for (int k = 0; !done; k++) begin
                ack_now = (k == ack_lat);
                to_now  = !ack_now && (k == TO - 1);
                bus_ack = ack_now;
                bus_rdata = ack_now ? rdat : {$urandom, $urandom};
                clear = (k == clr_cyc);
                if (k == clr_cyc) flushed = 1'b1;
                @(negedge clk);
                chk({nm, ".req"}, 64'(bus_req), 64'd1);
                chk({nm, ".we"}, 64'(bus_we), 64'(st));
                chk({nm, ".addr"}, bus_addr, addr - (addr % 8));
                chk({nm, ".wstrb"}, 64'(bus_wstrb), 64'(m_wstrb(addr, sz)));
                chk({nm, ".wdata"}, bus_wdata, d2 << (8 * m_off(addr, sz)));
                chk({nm, ".stall"}, 64'(stall_out), 64'(!(ack_now || to_now)));
                tick();
                if (ack_now || to_now) begin
                    done = 1'b1;
                    chk({nm, ".valid"}, 64'(valid_out), 64'(!flushed));
                    chk({nm, ".fault"}, 64'(fault_out), 64'(to_now && !flushed));
                    chk({nm, ".mis"}, 64'(misalign_out), 64'd0);
                    if (!flushed && ack_now) begin
                        chk({nm, ".pc"}, pc_out, pc);
                        chk({nm, ".rd"}, 64'(rd_out), st ? 64'd0 : 64'(rd));
                        chk({nm, ".res"}, result_out, st ? 64'd0 : m_load(rdat, addr, sz, uns));
                    end
                end else begin
                    chk({nm, ".bubble"}, 64'(valid_out), 64'd0);
                end
            end
            bus_ack = 1'b0;
            clear = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; valid_in = 1'b1; load_op = 1'b1; store_op = 1'b0;
        size = 2'd3; unsigned_op = 1'b0; pc_in = 64'h1234; rd_in = 5'd7;
        result_in = 64'h40; data2_in = 64'h55; bus_ack = 1'b1; bus_rdata = 64'hDEAD;
        tick();
        tick();
        chk("rst.valid", 64'(valid_out), 64'd0);
        chk("rst.fault", 64'(fault_out), 64'd0);
        chk("rst.mis", 64'(misalign_out), 64'd0);
        chk("rst.pc", pc_out, 64'd0);
        chk("rst.rd", 64'(rd_out), 64'd0);
        chk("rst.res", result_out, 64'd0);
        chk("rst.req", 64'(bus_req), 64'd0);
        rst = 1'b0; valid_in = 1'b0; bus_ack = 1'b0;
        tick();

        // LW sign-extended, ack on the fourth BUS cycle.
        do_op("lw", 1, 1, 0, 2'd2, 0, 64'h1004, 64'h0, 64'h8000_0000_0000_0000, 3, -1, 0);
        chk("lw.res_abs", result_out, 64'hFFFF_FFFF_8000_0000);
        // SB into byte lane 3.
        do_op("sb", 1, 0, 1, 2'd0, 0, 64'h2003, 64'hAB, 64'h0, 0, -1, 0);
        // Back-to-back ALU ops.
        do_op("aluA", 1, 0, 0, 2'd3, 0, 64'hA, 64'h0, 64'h0, 0, -1, 0);
        do_op("aluB", 1, 0, 0, 2'd3, 0, 64'hB, 64'h0, 64'h0, 0, -1, 0);
        do_op("aluC", 1, 0, 0, 2'd3, 0, 64'hC, 64'h0, 64'h0, 0, -1, 0);
        // LD timeout.
        do_op("ldto", 1, 1, 0, 2'd3, 0, 64'h3000, 64'h0, 64'h0, 99, -1, 0);
        // LBU flushed mid-transaction, then a normal ALU op.
        do_op("lbuf", 1, 1, 0, 2'd0, 1, 64'h4005, 64'h0, 64'hFF00_0000_0000_0000, 2, 0, 0);
        do_op("aluD", 1, 0, 0, 2'd1, 0, 64'hD0D0, 64'h0, 64'h0, 0, -1, 0);
        // Store timeout after a clear: flushed fault is suppressed.
        do_op("sdtf", 1, 0, 1, 2'd3, 0, 64'h5000, 64'h77, 64'h0, 99, 1, 0);
        // LH at odd address.
        do_op("lhmis", 1, 1, 0, 2'd1, 0, 64'h1001, 64'h0, 64'h0000_0000_0000_8001, 0, -1, 0);
        // Clear and invalid in IDLE.
        do_op("clri", 1, 1, 0, 2'd3, 0, 64'h6000, 64'h0, 64'h0, 0, -1, 1);
        do_op("nov", 0, 1, 0, 2'd3, 0, 64'h6008, 64'h0, 64'h0, 0, -1, 0);

        // Reset in the middle of a BUS transaction.
        valid_in = 1'b1; load_op = 1'b1; store_op = 1'b0; size = 2'd3; clear = 1'b0;
        result_in = 64'h7000; bus_ack = 1'b0;
        tick();
        @(negedge clk);
        chk("rstbus.req_before", 64'(bus_req), 64'd1);
        rst = 1'b1;
        tick();
        chk("rstbus.req_after", 64'(bus_req), 64'd0);
        chk("rstbus.valid", 64'(valid_out), 64'd0);
        rst = 1'b0; valid_in = 1'b0;
        tick();
        do_op("postrst", 1, 0, 0, 2'd3, 0, 64'hE, 64'h0, 64'h0, 0, -1, 0);

        // Randomized instruction stream.
        for (int i = 0; i < 300; i++) begin
            int kind = int'($urandom_range(0, 9));
            bit ld = (kind >= 3 && kind <= 5);
            bit st = (kind >= 6 && kind <= 8);
            bit vld = (kind != 9);
            int lat = int'($urandom_range(0, TO + 1));
            int cc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
            bit ci = ($urandom_range(0, 15) == 0);
            do_op("rnd", vld, ld, st, 2'($urandom), 1'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, lat, cc, ci);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
